reg_bank_read: RTL and testbench

REG_BANK_READ -- requirements
Module: reg_bank_read

---
 rtl/reg_bank_read_if.sv | 30 +++
 rtl/reg_bank_read.sv | 83 ++++++++
 tb/tb_reg_bank_read.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_read_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_read_if
// Description : Write-enable/data and dual read-port bundle for reg_bank_read.
// Revision    : 1.0
// ============================================================================
interface reg_bank_read_if #(
    parameter int XLEN = 32
);
    logic [31:0]     enS;
    logic [XLEN-1:0] wd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_req;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rd_valid;
    logic            wr_err;

    modport master (
        output enS, wd, rs1, rs2, rd_req,
        input  rd1, rd2, rd_valid, wr_err
    );

    modport slave (
        input  enS, wd, rs1, rs2, rd_req,
        output rd1, rd2, rd_valid, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_read.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_read
// Description : 32 x XLEN register bank, one-hot write enable with illegal
//               pattern detection, registered dual read with write bypass.
// Revision    : 1.0
// ============================================================================
module reg_bank_read #(
    parameter int XLEN = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_bank_read_if.slave  bus
);
    localparam int c_NREGS = 32;

    logic [XLEN-1:0] r_regs [c_NREGS];
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic            r_rd_valid;
    logic            r_wr_err;

    logic            w_any;
    logic            w_onehot;
    logic            w_multi;
    logic            w_wr_legal;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    assign w_any      = (bus.enS != 32'd0);
    assign w_onehot   = w_any && ((bus.enS & (bus.enS - 32'd1)) == 32'd0);
    assign w_multi    = w_any && !w_onehot;
    assign w_wr_legal = w_onehot && !bus.enS[0];

    // A legal write to the addressed register is forwarded; x0 is hardwired.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (bus.rs1 != 5'd0) begin
            w_rd1 = (w_wr_legal && bus.enS[bus.rs1]) ? bus.wd : r_regs[bus.rs1];
        end
        if (bus.rs2 != 5'd0) begin
            w_rd2 = (w_wr_legal && bus.enS[bus.rs2]) ? bus.wd : r_regs[bus.rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_legal) begin
            for (int i = 1; i < c_NREGS; i++) begin
                if (bus.enS[i]) begin
                    r_regs[i] <= bus.wd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            r_wr_err   <= r_wr_err | w_multi;
            if (bus.rd_req) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    assign bus.rd1      = r_rd1;
    assign bus.rd2      = r_rd2;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_err   = r_wr_err;
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_read.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_read
// Description : Directed self-checking bench for reg_bank_read.
// Revision    : 1.0
// ============================================================================
module tb_reg_bank_read;
    localparam int c_XLEN = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    reg_bank_read_if #(.XLEN(c_XLEN)) bus ();

    reg_bank_read #(.XLEN(c_XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] en, input logic [31:0] d, input logic req,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.enS    = en;
        bus.wd     = d;
        bus.rd_req = req;
        bus.rs1    = a1;
        bus.rs2    = a2;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Reset with a pending write and read
        rst = 1'b1;
        drive(32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd5);
        step();
        check("rst_rd1",      bus.rd1, 32'h0);
        check("rst_rd2",      bus.rd2, 32'h0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'h0);
        check("rst_wr_err",   {31'd0, bus.wr_err}, 32'h0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 5'd5, 5'd0);
        step();
        check("rst_x5_read", bus.rd1, 32'h0);
        check("rst_x5_vld",  {31'd0, bus.rd_valid}, 32'h1);

        // Basic write then read
        drive(32'h0000_0008, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
        step();
        drive(32'h0, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("basic_rd1", bus.rd1, 32'h1234_5678);
        check("basic_rd2", bus.rd2, 32'h0);
        check("basic_vld", {31'd0, bus.rd_valid}, 32'h1);

        // Hold while not requesting, even across a write to the read register
        drive(32'h0000_0008, 32'h0000_0009, 1'b0, 5'd3, 5'd3);
        step();
        check("hold_rd1", bus.rd1, 32'h1234_5678);
        check("hold_vld", {31'd0, bus.rd_valid}, 32'h0);
        drive(32'h0, 32'h0, 1'b0, 5'd3, 5'd3);
        step();
        check("hold2_rd1", bus.rd1, 32'h1234_5678);
        drive(32'h0, 32'h0, 1'b1, 5'd3, 5'd3);
        step();
        check("same_rd1", bus.rd1, 32'h9);
        check("same_rd2", bus.rd2, 32'h9);

        // Bypass on both ports
        drive(32'h8000_0000, 32'hA5A5_A5A5, 1'b1, 5'd31, 5'd31);
        step();
        check("byp_rd1", bus.rd1, 32'hA5A5_A5A5);
        check("byp_rd2", bus.rd2, 32'hA5A5_A5A5);

        // Bypass on port 2 only
        drive(32'h0000_0080, 32'h0000_0077, 1'b1, 5'd3, 5'd7);
        step();
        check("byp2_rd1", bus.rd1, 32'h9);
        check("byp2_rd2", bus.rd2, 32'h77);

        // x0 protection
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd3);
        step();
        check("x0_rd1",    bus.rd1, 32'h0);
        check("x0_rd2",    bus.rd2, 32'h9);
        check("x0_wr_err", {31'd0, bus.wr_err}, 32'h0);
        drive(32'h0, 32'h0, 1'b1, 5'd0, 5'd31);
        step();
        check("x0_again", bus.rd1, 32'h0);
        check("x31_keep", bus.rd2, 32'hA5A5_A5A5);

        // Illegal pattern: no write, no bypass, sticky error
        drive(32'h0000_0010, 32'h0000_0011, 1'b0, 5'd0, 5'd0);
        step();
        drive(32'h0000_0020, 32'h0000_0022, 1'b0, 5'd0, 5'd0);
        step();
        check("pre_ill_err", {31'd0, bus.wr_err}, 32'h0);
        drive(32'h0000_0030, 32'h0000_00FF, 1'b1, 5'd4, 5'd5);
        step();
        check("ill_rd1", bus.rd1, 32'h11);
        check("ill_rd2", bus.rd2, 32'h22);
        check("ill_err", {31'd0, bus.wr_err}, 32'h1);
        drive(32'h0, 32'h0, 1'b1, 5'd5, 5'd4);
        step();
        check("ill_x5", bus.rd1, 32'h22);
        check("ill_x4", bus.rd2, 32'h11);
        drive(32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("sticky_err", {31'd0, bus.wr_err}, 32'h1);
        end

        // Reset mid-operation discards the in-flight read
        rst = 1'b1;
        drive(32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 5'd4, 5'd5);
        step();
        check("rst2_err", {31'd0, bus.wr_err}, 32'h0);
        check("rst2_vld", {31'd0, bus.rd_valid}, 32'h0);
        check("rst2_rd1", bus.rd1, 32'h0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 5'd4, 5'd31);
        step();
        check("rst2_x4",  bus.rd1, 32'h0);
        check("rst2_x31", bus.rd2, 32'h0);

        // Two enables including bit 0 is still illegal
        drive(32'h0000_0003, 32'h0000_0055, 1'b1, 5'd1, 5'd1);
        step();
        check("ill0_rd1", bus.rd1, 32'h0);
        check("ill0_err", {31'd0, bus.wr_err}, 32'h1);
        drive(32'h0, 32'h0, 1'b1, 5'd1, 5'd0);
        step();
        check("ill0_x1", bus.rd1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
